// File: rtl/synth_pkg.sv
// Shared widths, types and mixer FSM encoding for the additive oscillator bank.
// Also builds the quarter-wave sine table at elaboration time using fixed-point Taylor series.
package synth_pkg;

  localparam int SAMPLE_W   = 16;
  localparam int PHASE_W    = 24;
  localparam int AMP_W      = 8;
  localparam int LUT_ADDR_W = 10;
  localparam int QW_N       = 2 ** (LUT_ADDR_W - 2);

  typedef logic signed [SAMPLE_W-1:0] sample_t;
  typedef logic [PHASE_W-1:0]         phase_t;
  typedef logic [AMP_W-1:0]           amp_t;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, OUT} mix_state_t;

  localparam logic signed [127:0] PI_Q40 = 128'sd3454217652358;

  // Entry i = round(32767*sin(2*pi*(i+0.5)/2^LUT_ADDR_W)), angle in Q40, series to x^21.
  function automatic logic [SAMPLE_W*QW_N-1:0] build_qtab();
    logic [SAMPLE_W*QW_N-1:0] tab;
    logic signed [127:0]      x, x2, term, sum, r;
    tab = '0;
    for (int i = 0; i < QW_N; i++) begin
      x    = (PI_Q40 * 128'(2 * i + 1)) >>> LUT_ADDR_W;
      x2   = (x * x) >>> 40;
      term = x;
      sum  = x;
      for (int n = 1; n <= 10; n++) begin
        term = -(((term * x2) >>> 40) / 128'(2 * n * (2 * n + 1)));
        sum  = sum + term;
      end
      r = (sum * 128'sd32767 + (128'sd1 <<< 39)) >>> 40;
      tab[i*SAMPLE_W +: SAMPLE_W] = r[SAMPLE_W-1:0];
    end
    return tab;
  endfunction

endpackage

// File: rtl/sine_lut.sv
// Full-cycle sine lookup from a quarter-wave ROM with mirror/negate on the top address bits.
// Latency 1 cycle (registered output); no flow control, accepts an address every cycle.
module sine_lut
  import synth_pkg::*;
(
  input  logic                        clk,
  input  logic [LUT_ADDR_W-1:0]       addr,
  output logic signed [SAMPLE_W-1:0]  sine
);

  localparam logic [SAMPLE_W*QW_N-1:0] QTAB = build_qtab();

  logic [LUT_ADDR_W-3:0]       qidx;
  logic signed [SAMPLE_W-1:0]  qval;

  // Half-sample offset in the table makes the second/fourth quarter an exact bitwise mirror.
  always_comb begin
    qidx = addr[LUT_ADDR_W-2] ? ~addr[LUT_ADDR_W-3:0] : addr[LUT_ADDR_W-3:0];
    qval = QTAB[32'(qidx)*SAMPLE_W +: SAMPLE_W];
  end

  always_ff @(posedge clk) begin
    sine <= addr[LUT_ADDR_W-1] ? -qval : qval;
  end

endmodule

// File: rtl/partial_bank_mixer.sv
// Additive oscillator bank: one sweep of N_PARTIALS phase accumulators per sample, summed and saturated.
// Sample strobe lands N_PARTIALS+5 cycles after count==0; no backpressure, a start seen while busy sets overrun.
module partial_bank_mixer
  import synth_pkg::*;
#(
  parameter int N_PARTIALS = 64
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [11:0]                   sample_cycle_count,
  input  logic                          cfg_we,
  input  logic [$clog2(N_PARTIALS)-1:0] cfg_addr,
  input  logic [PHASE_W-1:0]            cfg_phase_inc,
  input  logic [AMP_W-1:0]              cfg_amp,
  output logic signed [SAMPLE_W-1:0]    sample_out,
  output logic                          sample_valid,
  output logic                          busy,
  output logic                          overrun
);

  localparam int IDX_W  = $clog2(N_PARTIALS);
  localparam int PROD_W = SAMPLE_W + AMP_W + 1;
  localparam int ACC_W  = SAMPLE_W + AMP_W + IDX_W + 1;
  localparam logic [IDX_W-1:0]        LAST_IDX = IDX_W'(N_PARTIALS - 1);
  localparam logic signed [ACC_W-1:0] SAT_MAX  = ACC_W'(2 ** (SAMPLE_W - 1) - 1);
  localparam logic signed [ACC_W-1:0] SAT_MIN  = ACC_W'(-(2 ** (SAMPLE_W - 1)));

  mix_state_t       state, state_n;
  logic [IDX_W-1:0] k_cnt, k_cnt_n;
  logic             issue, acc_clr;

  phase_t ph_mem  [N_PARTIALS];
  phase_t inc_mem [N_PARTIALS];
  amp_t   amp_mem [N_PARTIALS];
  logic [N_PARTIALS-1:0] ph_ok, cfg_ok;

  logic             v1, v2, v3, v4;
  logic             last1, last2, last3, last4;
  logic [IDX_W-1:0] idx1;
  phase_t           ph1, inc1;
  amp_t             amp1, amp2, amp3;
  logic [LUT_ADDR_W-1:0]      a2;
  logic signed [SAMPLE_W-1:0] sine3;
  logic signed [PROD_W-1:0]   prod4;
  logic signed [ACC_W-1:0]    acc, acc_fin, acc_shr;
  logic signed [SAMPLE_W-1:0] sat_val;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      k_cnt <= '0;
    end else begin
      state <= state_n;
      k_cnt <= k_cnt_n;
    end
  end

  always_comb begin
    state_n = state;
    k_cnt_n = k_cnt;
    issue   = 1'b0;
    acc_clr = 1'b0;
    case (state)
      IDLE: if (sample_cycle_count == 12'd0) begin
        state_n = RUN;
        k_cnt_n = '0;
        acc_clr = 1'b1;
      end
      RUN: begin
        issue   = 1'b1;
        k_cnt_n = k_cnt + 1'b1;
        if (k_cnt == LAST_IDX) state_n = DRAIN;
      end
      DRAIN: if (v4 && last4) state_n = OUT;
      OUT:   state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // RAM contents cannot be reset, so per-entry valid bits make unwritten entries read as zero.
  always_ff @(posedge clk) begin
    if (!rst && cfg_we) begin
      inc_mem[cfg_addr] <= cfg_phase_inc;
      amp_mem[cfg_addr] <= cfg_amp;
    end
    if (!rst && v1) ph_mem[idx1] <= ph1 + inc1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cfg_ok <= '0;
      ph_ok  <= '0;
    end else begin
      if (cfg_we) cfg_ok[cfg_addr] <= 1'b1;
      if (v1)     ph_ok[idx1]      <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
      v3 <= 1'b0;
      v4 <= 1'b0;
    end else begin
      v1 <= issue;
      v2 <= v1;
      v3 <= v2;
      v4 <= v3;
    end
  end

  always_ff @(posedge clk) begin
    idx1  <= k_cnt;
    last1 <= (k_cnt == LAST_IDX);
    ph1   <= ph_ok[k_cnt]  ? ph_mem[k_cnt]  : '0;
    inc1  <= cfg_ok[k_cnt] ? inc_mem[k_cnt] : '0;
    amp1  <= cfg_ok[k_cnt] ? amp_mem[k_cnt] : '0;
    a2    <= ph1[PHASE_W-1 -: LUT_ADDR_W];
    amp2  <= amp1;
    last2 <= last1;
    amp3  <= amp2;
    last3 <= last2;
    prod4 <= PROD_W'(sine3) * PROD_W'($signed({1'b0, amp3}));
    last4 <= last3;
  end

  sine_lut u_sine_lut (
    .clk  (clk),
    .addr (a2),
    .sine (sine3)
  );

  // The final product is folded in combinationally so the strobe appears as the pipeline empties.
  always_comb begin
    acc_fin = acc + ACC_W'(prod4);
    acc_shr = acc_fin >>> AMP_W;
    if (acc_shr > SAT_MAX)      sat_val = SAT_MAX[SAMPLE_W-1:0];
    else if (acc_shr < SAT_MIN) sat_val = SAT_MIN[SAMPLE_W-1:0];
    else                        sat_val = acc_shr[SAMPLE_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc          <= '0;
      sample_out   <= '0;
      sample_valid <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      if (acc_clr)  acc <= '0;
      else if (v4)  acc <= acc_fin;
      sample_valid <= v4 && last4;
      if (v4 && last4) sample_out <= sat_val;
      if (state != IDLE && sample_cycle_count == 12'd0) overrun <= 1'b1;
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_partial_bank_mixer.sv
// Randomized bench for partial_bank_mixer: a real-valued sine reference model predicts each sample,
// and a negedge monitor compares strobes, held output, busy and overrun against the queued predictions.
module tb_partial_bank_mixer;

  localparam int N = 64;

  logic               clk = 1'b0;
  logic               rst;
  logic [11:0]        cnt;
  logic               cfg_we;
  logic [5:0]         cfg_addr;
  logic [23:0]        cfg_inc;
  logic [7:0]         cfg_amp;
  logic signed [15:0] sample_out;
  logic               sample_valid, busy, overrun;

  always #5 clk = ~clk;

  partial_bank_mixer #(.N_PARTIALS(N)) dut (
    .clk                (clk),
    .rst                (rst),
    .sample_cycle_count (cnt),
    .cfg_we             (cfg_we),
    .cfg_addr           (cfg_addr),
    .cfg_phase_inc      (cfg_inc),
    .cfg_amp            (cfg_amp),
    .sample_out         (sample_out),
    .sample_valid       (sample_valid),
    .busy               (busy),
    .overrun            (overrun)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  int unsigned m_ph [N];
  int unsigned m_inc[N];
  int          m_amp[N];
  bit          m_act = 1'b0;
  bit          m_ovr = 1'b0;
  int          m_T   = 0;
  longint      m_acc = 0;

  typedef struct {int val; int at;} exp_t;
  exp_t q[$];
  exp_t e;
  bit   exp_busy = 1'b0;
  bit   exp_ovr  = 1'b0;
  bit   mon_en   = 1'b0;
  int   hold     = 0;
  int   hold_zero_at = -1;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
    end
  endtask

  function automatic int msine(input int a);
    real ang;
    ang = 2.0 * 3.14159265358979323846 * (real'(a) + 0.5) / 1024.0;
    return int'($floor(32767.0 * $sin(ang) + 0.5));
  endfunction

  function automatic int sat16(input longint v);
    if (v > 32767)  return 32767;
    if (v < -32768) return -32768;
    return int'(v);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_ph[i]  = 0;
      m_inc[i] = 0;
      m_amp[i] = 0;
    end
    m_act = 1'b0;
    m_ovr = 1'b0;
  endtask

  // One clock cycle: drive inputs, advance the reference model by this cycle's rules, clock.
  task automatic tick(input bit r, input int c, input bit we, input int a, input int inc, input int amp);
    int k;
    rst      = r;
    cnt      = c[11:0];
    cfg_we   = we;
    cfg_addr = a[5:0];
    cfg_inc  = inc[23:0];
    cfg_amp  = amp[7:0];
    exp_busy = m_act && (cyc > m_T) && (cyc <= m_T + N + 5);
    exp_ovr  = m_ovr;
    if (r) begin
      model_reset();
      hold_zero_at = cyc + 1;
    end else begin
      if (c == 0) begin
        if (exp_busy) m_ovr = 1'b1;
        else begin
          m_act = 1'b1;
          m_T   = cyc;
          m_acc = 0;
        end
      end
      if (m_act && cyc >= m_T + 1 && cyc <= m_T + N) begin
        k = cyc - m_T - 1;
        m_acc += longint'(msine(int'(m_ph[k] >> 14))) * m_amp[k];
        m_ph[k] = (m_ph[k] + m_inc[k]) & 32'h00FF_FFFF;
        if (cyc == m_T + N) q.push_back('{sat16(m_acc >>> 8), m_T + N + 5});
      end
      if (m_act && cyc >= m_T + N + 5) m_act = 1'b0;
      if (we) begin
        m_inc[a] = inc & 32'h00FF_FFFF;
        m_amp[a] = amp & 255;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic cfg(input int a, input int inc, input int amp);
    tick(1'b0, 1, 1'b1, a, inc, amp);
  endtask

  task automatic period(input int len, input bit rnd_wr);
    for (int c = 0; c < len; c++) begin
      if (rnd_wr && $urandom_range(0, 3) == 0)
        tick(1'b0, c, 1'b1, int'($urandom_range(0, N - 1)), int'($urandom), int'($urandom_range(0, 63)));
      else
        tick(1'b0, c, 1'b0, 0, 0, 0);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (cyc == hold_zero_at) hold = 0;
      check("busy", longint'(busy), longint'(exp_busy));
      check("overrun", longint'(overrun), longint'(exp_ovr));
      while (q.size() > 0 && q[0].at < cyc) begin
        e = q.pop_front();
        check("missed_sample", 0, 1);
      end
      if (q.size() > 0 && q[0].at == cyc) begin
        e = q.pop_front();
        check("valid", longint'(sample_valid), 1);
        check("sample", longint'(sample_out), longint'(e.val));
        hold = e.val;
      end else begin
        check("valid_idle", longint'(sample_valid), 0);
        check("hold", longint'(sample_out), longint'(hold));
      end
    end
  end

  initial begin
    model_reset();
    repeat (3) tick(1'b1, 1, 1'b0, 0, 0, 0);
    mon_en = 1'b1;
    check("rst_sample_out", longint'(sample_out), 0);
    check("rst_valid", longint'(sample_valid), 0);
    check("rst_busy", longint'(busy), 0);
    check("rst_overrun", longint'(overrun), 0);

    // Silent bank over full-length sample periods.
    repeat (2) period(2272, 1'b0);

    // Frozen phase, unity amplitude on partial 0.
    cfg(0, 0, 255);
    repeat (3) period(100, 1'b0);

    // Quarter-cycle step per sample.
    cfg(0, 1 << 22, 255);
    repeat (4) period(100, 1'b0);

    // Two aligned partials drive both saturation limits.
    tick(1'b1, 1, 1'b0, 0, 0, 0);
    cfg(0, 1 << 22, 255);
    cfg(1, 1 << 22, 255);
    repeat (4) period(100, 1'b0);

    // Random bank with random writes landing mid-sweep.
    for (int i = 0; i < N; i++) cfg(i, int'($urandom), int'($urandom_range(0, 63)));
    repeat (6) period(100, 1'b1);
    for (int i = 0; i < N; i++) cfg(i, int'($urandom), (i < 4) ? 255 : 0);
    repeat (3) period(100, 1'b1);

    // Second start 10 cycles into a sweep is ignored and latches overrun.
    for (int c = 0; c < 100; c++) tick(1'b0, (c == 10) ? 0 : c, 1'b0, 0, 0, 0);
    repeat (2) period(100, 1'b0);

    // Reset 20 cycles into a sweep aborts it; the bank then behaves as freshly reset.
    for (int c = 0; c < 100; c++) tick(c == 20, c, 1'b0, 0, 0, 0);
    check("post_rst_overrun", longint'(overrun), 0);
    cfg(0, 1 << 22, 255);
    repeat (3) period(100, 1'b0);

    repeat (5) tick(1'b0, 1, 1'b0, 0, 0, 0);
    check("queue_drained", longint'(q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
